// File: rtl/fbuf_pkg.sv
// Shared defaults and FSM encoding for the framebuffer port arbiter.
package fbuf_pkg;
  localparam int FBUF_ADDR_W     = 17;
  localparam int FBUF_DATA_W     = 12;
  localparam int FBUF_FIFO_DEPTH = 16;
  localparam int FBUF_WORDS_DEF  = 129600;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } fbuf_state_e;
endpackage

// File: rtl/fbuf_wr_fifo.sv
// Write queue: synchronous FIFO with extended-MSB pointers so full and empty differ.
module fbuf_wr_fifo #(
  parameter  int W     = 29,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty,
  output logic [AW:0]  o_level
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr, r_rptr;
  logic         w_push, w_pop;

  assign o_level = r_wptr - r_rptr;
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (o_level == FULL_LVL);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end
endmodule

// File: rtl/fbuf_port_arbiter.sv
// Single BRAM port owner: scanout reads win, fill and queued writes take the rest.
// A one-entry read cache absorbs repeated scanout addresses.
module fbuf_port_arbiter import fbuf_pkg::*; #(
  parameter  int ADDR_W     = FBUF_ADDR_W,
  parameter  int DATA_W     = FBUF_DATA_W,
  parameter  int FIFO_DEPTH = FBUF_FIFO_DEPTH,
  parameter  int FBUF_WORDS = FBUF_WORDS_DEF,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_clr_start,
  input  logic [DATA_W-1:0] i_clr_color,
  output logic              o_clr_busy,
  output logic [LVL_W-1:0]  o_fifo_level,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_ent_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FBUF_WORDS - 1);

  fbuf_state_e       r_state;
  logic [ADDR_W-1:0] r_clr_cnt, r_cache_addr;
  logic [DATA_W-1:0] r_clr_color, r_cache_data, r_rd_data, w_cache_nxt;
  logic              r_cache_valid, r_fill_pend, r_rd_v1;
  wr_ent_t           w_head, w_push_ent;
  logic              w_full, w_empty, w_push, w_pop, w_hit, w_rd_issue, w_fill, w_we_hit;
  logic [LVL_W-1:0]  w_level;

  assign w_push_ent   = '{addr: i_wr_addr, data: i_wr_data};
  assign o_wr_ready   = !i_rst && !w_full && (r_state == ST_RUN);
  assign w_push       = i_wr_valid && o_wr_ready;
  assign w_hit        = r_cache_valid && (i_rd_addr == r_cache_addr);
  assign w_rd_issue   = !i_rst && i_rd_en && !w_hit;
  assign w_fill       = !i_rst && !w_rd_issue && (r_state == ST_CLEAR);
  assign w_pop        = !i_rst && !w_rd_issue && !w_fill && (r_state != ST_CLEAR) && !w_empty;
  assign o_rd_data    = r_rd_data;
  assign o_clr_busy   = (r_state != ST_RUN);
  assign o_fifo_level = w_level;

  fbuf_wr_fifo #(.W($bits(wr_ent_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_wdata (w_push_ent),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_comb begin
    o_mem_en    = w_rd_issue || w_fill || w_pop;
    o_mem_we    = w_fill || w_pop;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_rd_issue) begin
      o_mem_addr = i_rd_addr;
    end else if (w_fill) begin
      o_mem_addr  = r_clr_cnt;
      o_mem_wdata = r_clr_color;
    end else if (w_pop) begin
      o_mem_addr  = w_head.addr;
      o_mem_wdata = w_head.data;
    end
  end

  // Cache tag is claimed at miss issue so back-to-back repeats hit; the data
  // lands a cycle later, and a same-address write overrides the stale BRAM word.
  assign w_we_hit = o_mem_we && r_cache_valid && (o_mem_addr == r_cache_addr);

  always_comb begin
    w_cache_nxt = r_cache_data;
    if (r_fill_pend) w_cache_nxt = i_mem_rdata;
    if (w_we_hit)    w_cache_nxt = o_mem_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_RUN;
      r_clr_cnt     <= '0;
      r_clr_color   <= '0;
      r_cache_addr  <= '0;
      r_cache_data  <= '0;
      r_cache_valid <= 1'b0;
      r_fill_pend   <= 1'b0;
      r_rd_v1       <= 1'b0;
      r_rd_data     <= '0;
    end else begin
      r_fill_pend  <= w_rd_issue;
      r_rd_v1      <= i_rd_en;
      r_rd_data    <= r_rd_v1 ? w_cache_nxt : '0;
      r_cache_data <= w_cache_nxt;
      if (w_rd_issue) begin
        r_cache_addr  <= i_rd_addr;
        r_cache_valid <= 1'b1;
      end
      case (r_state)
        ST_RUN: if (i_clr_start) begin
          r_clr_color <= i_clr_color;
          r_state     <= (!w_empty || w_push) ? ST_DRAIN : ST_CLEAR;
        end
        ST_DRAIN: if (w_empty) r_state <= ST_CLEAR;
        ST_CLEAR: if (w_fill) begin
          if (r_clr_cnt == LAST_ADDR) begin
            r_clr_cnt <= '0;
            r_state   <= ST_RUN;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_fbuf_port_arbiter.sv
// Bench for fbuf_port_arbiter: BRAM model, rd_data scoreboard, cache model, scenario sequences.
module tb_fbuf_port_arbiter;
  localparam int AW = 17;
  localparam int DW = 12;
  localparam int NW = 64;

  logic          clk = 1'b0, rst = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          wr_valid = 1'b0, wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          clr_start = 1'b0;
  logic [DW-1:0] clr_color = '0;
  logic          clr_busy;
  logic [4:0]    fifo_level;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  fbuf_port_arbiter #(.FBUF_WORDS(NW)) dut (
    .i_clk(clk), .i_rst(rst), .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_clr_start(clr_start), .i_clr_color(clr_color), .o_clr_busy(clr_busy),
    .o_fifo_level(fifo_level), .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  typedef struct {logic en; logic [AW-1:0] a; logic exp_en;} vec_t;

  logic [DW-1:0] bram   [1<<AW];
  logic [DW-1:0] ref_fb [1<<AW];
  int            nwr = 0, nrd = 0;
  wr_t           wlog[$];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        bram[mem_addr] <= mem_wdata;
        nwr <= nwr + 1;
        wlog.push_back({mem_addr, mem_wdata});
      end else begin
        mem_rdata <= bram[mem_addr];
        nrd <= nrd + 1;
      end
    end
  end

  int            errors = 0, checks = 0, acc = 0;
  wr_t           wq[$];
  logic [DW-1:0] sbq[$];
  logic          mc_v = 1'b0, last_mem_en = 1'b0;
  logic [AW-1:0] mc_a = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_wr(input int a, input int d);
    wr_t w;
    w.a = AW'(a);
    w.d = DW'(d);
    wq.push_back(w);
  endtask

  // One clock: offer queued write, check port use against the cache model, score rd_data.
  task automatic step();
    logic miss;
    if (wq.size() > 0) begin
      wr_valid = 1'b1; wr_addr = wq[0].a; wr_data = wq[0].d;
    end else begin
      wr_valid = 1'b0;
    end
    #1;
    last_mem_en = mem_en;
    miss = rd_en && !(mc_v && rd_addr == mc_a);
    if (miss) begin
      chk("rd_issue", {mem_en, mem_we, mem_addr}, {2'b10, rd_addr});
      mc_v = 1'b1; mc_a = rd_addr;
    end else if (rd_en) begin
      chk("rd_hit_no_read", 64'(mem_en && !mem_we), 64'd0);
    end
    if (wr_valid && wr_ready) begin
      void'(wq.pop_front());
      acc++;
    end
    sbq.push_back(rd_en ? ref_fb[rd_addr] : '0);
    @(posedge clk); #1;
    if (sbq.size() == 2) chk("rd_data", rd_data, sbq.pop_front());
  endtask

  vec_t tv[12];

  initial begin
    int w0, r0, a0, l0, bad;
    logic fell;
    for (int i = 0; i < (1<<AW); i++) begin
      bram[i] = DW'(i*37 + 5);
      ref_fb[i] = bram[i];
    end
    bram[9] = 12'h123; ref_fb[9] = 12'h123;

    // reset state
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
    chk("rst_out", {rd_data, wr_ready, clr_busy, fifo_level}, 64'd0);
    rst = 1'b0; #1;
    chk("post_rst", {wr_ready, clr_busy, fifo_level}, {1'b1, 1'b0, 5'd0});

    // 1: reads only, cache absorbs repeats
    tv = '{'{1'b1, 17'd5, 1'b1}, '{1'b1, 17'd5, 1'b0}, '{1'b1, 17'd5, 1'b0}, '{1'b1, 17'd5, 1'b0},
           '{1'b1, 17'd6, 1'b1}, '{1'b1, 17'd6, 1'b0}, '{1'b1, 17'd6, 1'b0}, '{1'b1, 17'd6, 1'b0},
           '{1'b0, 17'd6, 1'b0}, '{1'b1, 17'd6, 1'b0}, '{1'b1, 17'd5, 1'b1}, '{1'b1, 17'd5, 1'b0}};
    r0 = nrd;
    for (int i = 0; i < 12; i++) begin
      rd_en = tv[i].en; rd_addr = tv[i].a;
      step();
      chk($sformatf("t1_mem_en[%0d]", i), 64'(last_mem_en), 64'(tv[i].exp_en));
      if (i == 7) chk("t1_reads_8", nrd - r0, 64'd2);
    end
    rd_en = 1'b0; step(); step();

    // 2: writes interleaved with scanout repeating every 4 cycles
    w0 = nwr;
    for (int i = 0; i < 8; i++) push_wr(256 + i, 2048 + i);
    for (int s = 0; s < 60; s++) begin
      if (wq.size() == 0 && fifo_level == 0) break;
      rd_en = 1'b1; rd_addr = AW'(64 + s/4);
      step();
    end
    chk("t2_level", fifo_level, 64'd0);
    chk("t2_nwr", nwr - w0, 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_bram[%0d]", i), bram[256+i], 64'(2048 + i));
      ref_fb[256+i] = DW'(2048 + i);
    end

    // 3: backpressure under continuous read misses
    w0 = nwr; a0 = acc;
    for (int i = 0; i < 20; i++) push_wr(768 + i, 1024 + i);
    rd_en = 1'b1;
    for (int s = 0; s < 24; s++) begin
      rd_addr = AW'(512 + s);
      step();
    end
    chk("t3_accepted", acc - a0, 64'd16);
    chk("t3_level", fifo_level, 64'd16);
    chk("t3_ready", 64'(wr_ready), 64'd0);
    chk("t3_no_write", nwr - w0, 64'd0);
    rd_en = 1'b0;
    for (int s = 0; s < 100; s++) begin
      if (wq.size() == 0 && fifo_level == 0) break;
      step();
    end
    chk("t3_nwr", nwr - w0, 64'd20);
    chk("t3_bram0", bram[768], 64'd1024);
    chk("t3_bram15", bram[783], 64'd1039);
    chk("t3_bram19", bram[787], 64'd1043);

    // 4: write into cached address updates the cache
    rd_en = 1'b1; rd_addr = 17'd9;
    step(); step(); step();
    rd_en = 1'b0;
    push_wr(9, 12'hABC);
    for (int s = 0; s < 20; s++) begin
      if (wq.size() == 0 && fifo_level == 0) break;
      step();
    end
    chk("t4_bram9", bram[9], 64'hABC);
    ref_fb[9] = 12'hABC;
    rd_en = 1'b1; rd_addr = 17'd9;
    step(); step(); step();
    rd_en = 1'b0; step(); step();

    // 5: clear with writes queued, extra clr_start ignored while busy
    w0 = nwr; l0 = wlog.size();
    for (int i = 0; i < 3; i++) push_wr(1280 + i, 1792 + i);
    rd_en = 1'b1;
    for (int s = 0; s < 4; s++) begin
      rd_addr = AW'(1536 + s);
      step();
    end
    chk("t5_queued", fifo_level, 64'd3);
    clr_color = 12'h0F0; clr_start = 1'b1; rd_addr = 17'd1540;
    step();
    clr_start = 1'b0; clr_color = '0;
    chk("t5_busy", 64'(clr_busy), 64'd1);
    chk("t5_ready_drain", 64'(wr_ready), 64'd0);
    rd_en = 1'b0;
    step();
    clr_start = 1'b1; clr_color = 12'hFFF;
    step();
    clr_start = 1'b0;
    fell = 1'b0;
    for (int s = 0; s < 300; s++) begin
      clr_start = (s == 10); clr_color = 12'hFFF;
      step();
      if (!clr_busy) begin
        fell = 1'b1;
        chk("t5_writes_at_fall", nwr - w0, 64'(3 + NW));
        break;
      end
    end
    clr_start = 1'b0;
    chk("t5_fell", 64'(fell), 64'd1);
    for (int i = 0; i < 3; i++)
      if (wlog.size() > l0 + i) chk($sformatf("t5_drain[%0d]", i), wlog[l0+i], {AW'(1280 + i), DW'(1792 + i)});
      else chk($sformatf("t5_drain[%0d]", i), 64'(wlog.size()), 64'(l0 + 3));
    bad = 0;
    for (int i = 0; i < NW; i++) begin
      if (bram[i] !== 12'h0F0) bad++;
      ref_fb[i] = 12'h0F0;
    end
    chk("t5_fill_words", bad, 64'd0);
    chk("t5_past_end", bram[NW], ref_fb[NW]);

    // 6: reset in the middle of a fill
    clr_color = 12'h00F; clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    for (int s = 0; s < 10; s++) step();
    chk("t6_busy", 64'(clr_busy), 64'd1);
    rd_en = 1'b1; rd_addr = 17'd1800;
    rst = 1'b1; #1;
    chk("t6_rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
    chk("t6_rst_out", {rd_data, wr_ready, clr_busy, fifo_level}, 64'd0);
    sbq.delete(); mc_v = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; rd_en = 1'b0; #1;
    chk("t6_post", {wr_ready, clr_busy, fifo_level}, {1'b1, 1'b0, 5'd0});
    chk("t6_abandoned", bram[NW-1], 64'h0F0);
    w0 = nwr;
    step(); step();
    chk("t6_idle", {31'(nwr - w0), clr_busy}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
